// File: rtl/i_mem_pkg.sv
// Shared types and elaboration helpers for the burst instruction memory.
package i_mem_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  function automatic int beats(input int line_bytes, input int beat_bytes);
    return line_bytes / beat_bytes;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int line_bytes, input int beat_bytes,
                                      input int depth_bytes);
    return is_pow2(line_bytes) && is_pow2(beat_bytes) && is_pow2(depth_bytes) &&
           (line_bytes >= beat_bytes) && (depth_bytes % line_bytes == 0);
  endfunction

endpackage

// File: rtl/i_mem_byte_array.sv
// Byte storage with one beat-wide combinational read port.
module i_mem_byte_array #(
  parameter int    BEAT_BYTES  = 1,
  parameter int    DEPTH_BYTES = 1024,
  parameter int    BA_W        = 10,
  parameter string INIT_FILE   = ""
) (
  input  logic [BA_W-1:0]         beat_addr,
  output logic [8*BEAT_BYTES-1:0] beat_data
);

  localparam int DA_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0] mem [DEPTH_BYTES];

  always_comb begin
    beat_data = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      beat_data[8*k +: 8] = mem[DA_W'(beat_addr) * DA_W'(BEAT_BYTES) + DA_W'(k)];
    end
  end

endmodule

// File: rtl/i_mem_burst.sv
// Instruction memory returning one cache line over LINE_BYTES/BEAT_BYTES beats
// on a READ_EN/BUSYWAIT handshake, with a one-cycle READ_VALID completion pulse.
module i_mem_burst
  import i_mem_pkg::*;
#(
  parameter int    LINE_BYTES  = 16,
  parameter int    BEAT_BYTES  = 1,
  parameter int    ADDR_W      = 28,
  parameter int    DEPTH_BYTES = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    READ_EN,
  input  logic [ADDR_W-1:0]       READ_ADDR,
  output logic                    BUSYWAIT,
  output logic [8*LINE_BYTES-1:0] READ_DATA,
  output logic                    READ_VALID
);

  localparam int N      = beats(LINE_BYTES, BEAT_BYTES);
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BA_W   = (DEPTH_BYTES / BEAT_BYTES > 1) ? $clog2(DEPTH_BYTES / BEAT_BYTES) : 1;
  localparam int FULL_W = ADDR_W + CNT_W;

  if (!params_legal(LINE_BYTES, BEAT_BYTES, DEPTH_BYTES)) begin : g_bad_params
    $error("i_mem_burst: illegal LINE_BYTES/BEAT_BYTES/DEPTH_BYTES combination");
  end

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic                    last_beat;
  logic [BA_W-1:0]         beat_addr;
  logic [8*BEAT_BYTES-1:0] beat_data;

  assign last_beat = (beat_cnt == CNT_W'(N - 1));

  // Truncating the beat index to BA_W bits is what wraps addresses past DEPTH_BYTES.
  assign beat_addr = BA_W'(FULL_W'(addr_q) * FULL_W'(N) + FULL_W'(beat_cnt));

  assign BUSYWAIT = READ_EN & (state != DONE) & ~RESET;

  i_mem_byte_array #(
    .BEAT_BYTES  (BEAT_BYTES),
    .DEPTH_BYTES (DEPTH_BYTES),
    .BA_W        (BA_W),
    .INIT_FILE   (INIT_FILE)
  ) u_mem (
    .beat_addr (beat_addr),
    .beat_data (beat_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (READ_EN) state_nxt = FETCH;
      // A final beat wins over a simultaneous READ_EN drop.
      FETCH:   if (last_beat) state_nxt = DONE;
               else if (!READ_EN) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      addr_q     <= '0;
      READ_DATA  <= '0;
      READ_VALID <= 1'b0;
    end else begin
      state      <= state_nxt;
      READ_VALID <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (READ_EN) begin
            addr_q   <= READ_ADDR;
            beat_cnt <= '0;
          end
        end
        FETCH: begin
          READ_DATA[int'(beat_cnt)*8*BEAT_BYTES +: 8*BEAT_BYTES] <= beat_data;
          beat_cnt <= beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_burst.sv
// Directed bench for i_mem_burst: default 1-byte beats and a 4-byte-beat instance,
// both preloaded with image byte = byte_address[7:0].
module tb_i_mem_burst;

  logic         CLK;
  logic         RESET;

  logic         re1, bw1, rv1;
  logic [27:0]  ra1;
  logic [127:0] rd1;

  logic         re4, bw4, rv4;
  logic [27:0]  ra4;
  logic [127:0] rd4;

  int n_asrt = 0;
  int n_fail = 0;

  i_mem_burst dut1 (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ_EN    (re1),
    .READ_ADDR  (ra1),
    .BUSYWAIT   (bw1),
    .READ_DATA  (rd1),
    .READ_VALID (rv1)
  );

  i_mem_burst #(.BEAT_BYTES(4)) dut4 (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ_EN    (re4),
    .READ_ADDR  (ra4),
    .BUSYWAIT   (bw4),
    .READ_DATA  (rd4),
    .READ_VALID (rv4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected line contents for the address-byte image.
  function automatic logic [127:0] line_exp(input int line);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'((line * 16 + k) % 256);
    return v;
  endfunction

  // Call just after a falling edge; request cycle is the current one.
  task automatic fetch1(input logic [27:0] a, input int chg, input logic [27:0] a2,
                        input bit hold, output int busy, output logic vld);
    re1 = 1'b1; ra1 = a; busy = 0; vld = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == chg) ra1 = a2;
      #1;
      if (!bw1) begin vld = rv1; break; end
      busy++;
      @(negedge CLK);
    end
    if (!hold) re1 = 1'b0;
  endtask

  task automatic fetch4(input logic [27:0] a, output int busy, output logic vld);
    re4 = 1'b1; ra4 = a; busy = 0; vld = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bw4) begin vld = rv4; break; end
      busy++;
      @(negedge CLK);
    end
    re4 = 1'b0;
  endtask

  initial begin
    int   busy;
    int   pulses;
    logic vld;

    RESET = 1'b1;
    re1 = 1'b0; ra1 = '0;
    re4 = 1'b0; ra4 = '0;
    for (int i = 0; i < 1024; i++) begin
      dut1.u_mem.mem[i] = 8'(i);
      dut4.u_mem.mem[i] = 8'(i);
    end

    // Reset state, including BUSYWAIT suppressed while RESET is held.
    @(negedge CLK);
    re1 = 1'b1; ra1 = 28'h2;
    #1;
    chk("reset_data", rd1, '0);
    chk("reset_valid", {127'd0, rv1}, 128'd0);
    chk("reset_busy_with_req", {127'd0, bw1}, 128'd0);
    re1 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    // 4-byte beats, line 0x5.
    @(negedge CLK);
    fetch4(28'h5, busy, vld);
    chk("b4_busy_cycles", 128'(busy), 128'd5);
    chk("b4_valid", {127'd0, vld}, 128'd1);
    chk("b4_data", rd4, 128'h5f5e5d5c5b5a59585756555453525150);
    @(negedge CLK); #1;
    chk("b4_valid_single", {127'd0, rv4}, 128'd0);

    // Default config, line 0x2.
    @(negedge CLK);
    fetch1(28'h2, -1, '0, 1'b0, busy, vld);
    chk("line2_busy_cycles", 128'(busy), 128'd17);
    chk("line2_valid", {127'd0, vld}, 128'd1);
    chk("line2_data", rd1, 128'h2f2e2d2c2b2a29282726252423222120);
    @(negedge CLK); #1;
    chk("line2_valid_single", {127'd0, rv1}, 128'd0);

    // READ_ADDR moves to 0x7 mid-fetch; line 0x2 must still come back.
    @(negedge CLK);
    fetch1(28'h2, 4, 28'h7, 1'b0, busy, vld);
    chk("addr_chg_busy", 128'(busy), 128'd17);
    chk("addr_chg_data", rd1, 128'h2f2e2d2c2b2a29282726252423222120);

    // Abort after beat 5 has been written.
    @(negedge CLK);
    re1 = 1'b1; ra1 = 28'h9;
    repeat (7) @(negedge CLK);
    re1 = 1'b0;
    #1;
    chk("abort_busy_drop", {127'd0, bw1}, 128'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge CLK); #1;
      pulses += int'(rv1);
    end
    chk("abort_no_valid", 128'(pulses), 128'd0);

    @(negedge CLK);
    fetch1(28'h3, -1, '0, 1'b0, busy, vld);
    chk("refetch_busy", 128'(busy), 128'd17);
    chk("refetch_valid", {127'd0, vld}, 128'd1);
    chk("refetch_data", rd1, line_exp(3));

    // Reset asserted during beat 9 of a fetch.
    @(negedge CLK);
    re1 = 1'b1; ra1 = 28'h4;
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midrst_data", rd1, '0);
    chk("midrst_valid", {127'd0, rv1}, 128'd0);
    chk("midrst_busy", {127'd0, bw1}, 128'd0);
    re1 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    fetch1(28'h4, -1, '0, 1'b0, busy, vld);
    chk("postrst_busy", 128'(busy), 128'd17);
    chk("postrst_valid", {127'd0, vld}, 128'd1);
    chk("postrst_data", rd1, line_exp(4));

    // Line 0x40 wraps onto line 0x00 in a 1 KiB array.
    @(negedge CLK);
    fetch1(28'h40, -1, '0, 1'b0, busy, vld);
    chk("wrap_busy", 128'(busy), 128'd17);
    chk("wrap_data", rd1, 128'h0f0e0d0c0b0a09080706050403020100);

    // Back-to-back: READ_EN held through DONE restarts in the IDLE cycle.
    @(negedge CLK);
    fetch1(28'h1, -1, '0, 1'b1, busy, vld);
    chk("b2b_first_valid", {127'd0, vld}, 128'd1);
    chk("b2b_first_data", rd1, line_exp(1));
    @(negedge CLK);
    ra1 = 28'h6;
    #1;
    chk("b2b_idle_busy", {127'd0, bw1}, 128'd1);
    chk("b2b_idle_valid", {127'd0, rv1}, 128'd0);
    fetch1(28'h6, -1, '0, 1'b0, busy, vld);
    chk("b2b_second_busy", 128'(busy), 128'd17);
    chk("b2b_second_valid", {127'd0, vld}, 128'd1);
    chk("b2b_second_data", rd1, line_exp(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
